// File: rtl/pwr_cntr_scan_pkg.sv
// Shared definitions for the power-counter scanner: default geometry and FSM encoding.
package pwr_cntr_scan_pkg;

    localparam int NDIR_DEF     = 2;
    localparam int NUM_CNTR_DEF = 3;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SAMPLE,
        S_CLEAR,
        S_CLRHOLD,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/pwr_snap_rf.sv
// Snapshot register file: one stored value per counter, used to form per-sweep deltas.
module pwr_snap_rf #(
    parameter int NUM_CNTR = 3,
    parameter int DATA_W   = 32,
    parameter int AW       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_CNTR];

    // NOTE: this array is reset because the first sweep after reset must report delta == raw value;
    // plain storage arrays normally go without reset so they map onto RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNTR; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pwr_cntr_scan.sv
// Sweeps the power-counter memory, optionally clears each entry, and streams (id, value, delta) records.
module pwr_cntr_scan
    import pwr_cntr_scan_pkg::*;
#(
    parameter int NDIR     = NDIR_DEF,
    parameter int NUM_CNTR = NUM_CNTR_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr_en,
    output logic [NDIR-1:0]   dir,
    output logic              le,
    inout  wire  [DATA_W-1:0] dato,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [NDIR-1:0]   o_id,
    output logic [DATA_W-1:0] o_value,
    output logic [DATA_W-1:0] o_delta,
    output logic              busy,
    output logic              scan_done
);

    localparam logic [NDIR-1:0] LAST_IDX = NDIR'(NUM_CNTR - 1);

    state_t            state, state_nxt;
    logic [NDIR-1:0]   idx;
    logic              clr;
    logic [DATA_W-1:0] val, delta, snap_rd;
    logic              last;
    logic              snap_we;

    assign last    = (idx == LAST_IDX);
    assign snap_we = (state == S_EMIT) && o_ready;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_ADDR;
            S_ADDR:    state_nxt = S_SAMPLE;
            S_SAMPLE:  state_nxt = clr ? S_CLEAR : S_EMIT;
            S_CLEAR:   state_nxt = S_CLRHOLD;
            S_CLRHOLD: state_nxt = S_EMIT;
            S_EMIT:    if (o_ready) state_nxt = last ? S_DONE : S_ADDR;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            clr   <= 1'b0;
            val   <= '0;
            delta <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    clr <= clr_en;
                    idx <= '0;
                end
                S_SAMPLE: begin
                    val   <= dato;
                    delta <= dato - snap_rd;
                end
                S_EMIT: if (o_ready && !last) idx <= idx + 1'b1;
                S_DONE: idx <= '0;
                default: ;
            endcase
        end
    end

    pwr_snap_rf #(
        .NUM_CNTR (NUM_CNTR),
        .DATA_W   (DATA_W),
        .AW       (NDIR)
    ) u_snap_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (snap_we),
        .waddr (idx),
        .wdata (clr ? '0 : val),
        .raddr (idx),
        .rdata (snap_rd)
    );

    // Write strobe and bus drive decode straight from state, so an async reset releases the bus at once.
    assign le        = (state != S_CLEAR);
    assign dato      = (state == S_CLEAR) ? '0 : 'z;
    assign dir       = idx;
    assign o_valid   = (state == S_EMIT);
    assign o_id      = idx;
    assign o_value   = val;
    assign o_delta   = delta;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign scan_done = (state == S_DONE);

endmodule

// File: tb/tb_pwr_cntr_scan.sv
// Directed bench for pwr_cntr_scan with a behavioural counter memory on the DIR/LE/DATO port.
module tb_pwr_cntr_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clr_en = 1'b0;
    logic        o_ready = 1'b1;
    logic [1:0]  dir;
    logic        le;
    wire  [31:0] dato;
    logic        o_valid;
    logic [1:0]  o_id;
    logic [31:0] o_value, o_delta;
    logic        busy, scan_done;

    pwr_cntr_scan dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_en(clr_en),
        .dir(dir), .le(le), .dato(dato),
        .o_valid(o_valid), .o_ready(o_ready), .o_id(o_id),
        .o_value(o_value), .o_delta(o_delta),
        .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Counter memory: drives DATO while LE=1, captures DATO on posedge while LE=0.
    logic [31:0] mem [3];
    logic        tb_wr_en = 1'b0;
    logic [1:0]  tb_wr_addr = '0;
    logic [31:0] tb_wr_data = '0;

    assign dato = (le === 1'b1) ? mem[dir] : 'z;

    always @(posedge clk) begin
        if (tb_wr_en)          mem[tb_wr_addr] <= tb_wr_data;
        else if (le === 1'b0)  mem[dir] <= dato;
    end

    // Monitor on the falling edge: accepted records, done pulses, LE-low behaviour.
    logic [1:0]  rec_id  [64];
    logic [31:0] rec_val [64];
    logic [31:0] rec_dlt [64];
    int rec_cnt = 0, done_cnt = 0, le_low_cnt = 0, run = 0, max_run = 0, dir_viol = 0;
    logic       prev_le = 1'b1;
    logic [1:0] prev_dir = '0;

    always @(negedge clk) begin
        if (o_valid && o_ready && rec_cnt < 64) begin
            rec_id[rec_cnt]  <= o_id;
            rec_val[rec_cnt] <= o_value;
            rec_dlt[rec_cnt] <= o_delta;
            rec_cnt <= rec_cnt + 1;
        end
        if (scan_done) done_cnt <= done_cnt + 1;
        if (le === 1'b0) begin
            le_low_cnt <= le_low_cnt + 1;
            run <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else begin
            run <= 0;
        end
        if (prev_le === 1'b0 && dir !== prev_dir) dir_viol <= dir_viol + 1;
        prev_le  <= le;
        prev_dir <= dir;
    end

    int n_tests = 0, n_fail = 0;
    int rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        tb_wr_addr = a; tb_wr_data = d; tb_wr_en = 1'b1;
        @(posedge clk); #1;
        tb_wr_en = 1'b0;
    endtask

    task automatic start_sweep(input logic clr);
        @(posedge clk); #1;
        start = 1'b1; clr_en = clr;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (scan_done) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic check_rec(input string tag, input logic [1:0] id, input logic [31:0] v, input logic [31:0] d);
        check({tag, "_avail"}, (rd < rec_cnt), 1'b1);
        if (rd < rec_cnt) begin
            check({tag, "_id"},    rec_id[rd],  id);
            check({tag, "_value"}, rec_val[rd], v);
            check({tag, "_delta"}, rec_dlt[rd], d);
        end
        rd++;
    endtask

    initial begin
        int base_rec, base_done, base_low;
        logic found, stable;
        logic [1:0]  h_id, h_dir;
        logic [31:0] h_val, h_dlt;

        // Reset values
        #12;
        check("rst_le", le, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", scan_done, 1'b0);
        check("rst_dir", dir, 2'd0);
        check("rst_out", {o_id, o_value[29:0]} | o_delta, 32'd0);
        rst_n = 1'b1;

        // 1: plain sweep over {5,9,2}
        mem_write(0, 32'd5); mem_write(1, 32'd9); mem_write(2, 32'd2);
        start_sweep(1'b0);
        check("lat_addr_busy", busy, 1'b1);
        @(posedge clk); #1;
        check("lat_sample_valid", o_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_emit_valid", o_valid, 1'b1);
        base_done = done_cnt;
        wait_done("t1_done");
        // START in the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t1_done_once", done_cnt - base_done, 1);
        check("t1_start_in_done_busy", busy, 1'b0);
        check("t1_rec_count", rec_cnt, 3);
        check_rec("t1_r0", 0, 32'd5, 32'd5);
        check_rec("t1_r1", 1, 32'd9, 32'd9);
        check_rec("t1_r2", 2, 32'd2, 32'd2);
        check("t1_mem1", mem[1], 32'd9);

        // 2: counter 1 incremented to 12; a second START mid-sweep is ignored
        mem_write(1, 32'd12);
        base_done = done_cnt; base_rec = rec_cnt;
        start_sweep(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t2_done");
        repeat (10) @(posedge clk);
        #1;
        check("t2_no_queue_rec", rec_cnt - base_rec, 3);
        check("t2_no_queue_done", done_cnt - base_done, 1);
        check_rec("t2_r0", 0, 32'd5, 32'd0);
        check_rec("t2_r1", 1, 32'd12, 32'd3);
        check_rec("t2_r2", 2, 32'd2, 32'd0);

        // 3: clearing sweep over {7,7,7}; snapshots were {5,12,2}
        mem_write(0, 32'd7); mem_write(1, 32'd7); mem_write(2, 32'd7);
        base_low = le_low_cnt;
        start_sweep(1'b1);
        wait_done("t3_done");
        @(posedge clk); #1;
        check_rec("t3_r0", 0, 32'd7, 32'd2);
        check_rec("t3_r1", 1, 32'd7, 32'hFFFF_FFFB);
        check_rec("t3_r2", 2, 32'd7, 32'd5);
        check("t3_mem_cleared", mem[0] | mem[1] | mem[2], 32'd0);
        check("t3_le_low_cycles", le_low_cnt - base_low, 3);
        check("t3_le_low_run", max_run, 1);
        check("t3_dir_stable", dir_viol, 0);

        // 4: back-pressure on record 1; snapshots are 0 after the clearing sweep
        mem_write(0, 32'd4); mem_write(1, 32'd6); mem_write(2, 32'd8);
        base_rec = rec_cnt;
        start_sweep(1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (o_valid && o_id == 2'd0) found = 1'b1;
        end
        check("t4_rec0_seen", found, 1'b1);
        @(posedge clk); #1;
        o_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (o_valid) found = 1'b1;
        end
        check("t4_rec1_seen", found, 1'b1);
        h_id = o_id; h_val = o_value; h_dlt = o_delta; h_dir = dir;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || le !== 1'b1 || o_id !== h_id || o_value !== h_val ||
                o_delta !== h_dlt || dir !== h_dir) stable = 1'b0;
        end
        check("t4_stall_stable", stable, 1'b1);
        check("t4_stall_no_extra", rec_cnt - base_rec, 1);
        o_ready = 1'b1;
        wait_done("t4_done");
        @(posedge clk); #1;
        check_rec("t4_r0", 0, 32'd4, 32'd4);
        check_rec("t4_r1", 1, 32'd6, 32'd6);
        check_rec("t4_r2", 2, 32'd8, 32'd8);

        // 5: modular delta across wrap
        mem_write(0, 32'hFFFF_FFF0);
        start_sweep(1'b0);
        wait_done("t5a_done");
        @(posedge clk); #1;
        check_rec("t5a_r0", 0, 32'hFFFF_FFF0, 32'hFFFF_FFEC);
        rd += 2;
        mem_write(0, 32'h0000_0005);
        start_sweep(1'b0);
        wait_done("t5b_done");
        @(posedge clk); #1;
        check_rec("t5b_r0", 0, 32'h0000_0005, 32'h0000_0015);
        check_rec("t5b_r1", 1, 32'd6, 32'd0);
        rd += 1;

        // 6: reset asserted while the block drives the clear write
        mem_write(0, 32'd3); mem_write(1, 32'd4); mem_write(2, 32'd5);
        start_sweep(1'b1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (le === 1'b0) found = 1'b1;
        end
        check("t6_clear_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_le", le, 1'b1);
        check("t6_rst_valid", o_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_dato", dato, 32'd3);
        @(posedge clk); #1;
        check("t6_no_clear_write", mem[0], 32'd3);
        rst_n = 1'b1;
        rd = rec_cnt;
        start_sweep(1'b0);
        wait_done("t6_done");
        @(posedge clk); #1;
        check_rec("t6_r0", 0, 32'd3, 32'd3);
        check_rec("t6_r1", 1, 32'd4, 32'd4);
        check_rec("t6_r2", 2, 32'd5, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
